// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the memory responder.
// State encoding, word/lane/counter widths and a lane-mask helper.
package mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 4;
  localparam int LANES  = WORD_W / LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [LANES-1:0] lane_mask(
    input logic [1:0] off
  );
    lane_mask = LANES'(1) << off;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between an initiator and the responder.
// master: initiator side; slave: responder side.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_word_we;
  logic              req_byte_we;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wdata,
    output req_word_we, req_byte_we, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata,
    input  req_word_we, req_byte_we, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Word storage with per-lane synchronous write, async read.
// Ports: clk, rst (sync clear), we, lane_en, idx, wdata, rdata.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LANES-1:0]  lane_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic              in_range;

  assign in_range = 32'(idx) < 32'(DEPTH_WORDS);
  assign rdata = in_range ? mem_q[idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && in_range) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_en[l]) begin
          mem_q[idx][l*LANE_W +: LANE_W] <=
            wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE/BUSY/RESP handshake FSM.
// Ports: clock, reset (sync, high), bus (mem_responder_if.slave).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 3
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_M2 =
    CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              wwe_q, wwe_d;
  logic              bwe_q, bwe_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              enter_resp;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_wwe;
  logic              acc_bwe;
  logic              acc_err;
  logic              mem_we;
  logic [LANES-1:0]  mem_lanes;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;

  // With LATENCY==1 the access happens on the accept
  // edge itself, before the request has been captured.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wwe   = bus.req_word_we;
      acc_bwe   = bus.req_byte_we;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wwe   = wwe_q;
      acc_bwe   = bwe_q;
    end
  end

  always_comb begin
    acc_err = 1'b0;
    if ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS))
      acc_err = 1'b1;
    if (acc_wwe && acc_bwe)
      acc_err = 1'b1;
    if (acc_wwe && (acc_addr[1:0] != 2'b00))
      acc_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wwe_d   = wwe_q;
    bwe_d   = bwe_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wwe_d   = bus.req_word_we;
          bwe_d   = bus.req_byte_we;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M2;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d = cnt_q - 1'b1;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp =
    (state_d == RESP) && (state_q != RESP) && !reset;

  // Byte data is replicated so the lane mask alone
  // selects which lane lands in storage.
  assign mem_wdata = acc_bwe ? {LANES{acc_wdata[7:0]}}
                             : acc_wdata;
  assign mem_lanes = acc_bwe ? lane_mask(acc_addr[1:0])
                             : {LANES{1'b1}};
  assign mem_we = enter_resp && !acc_err &&
                  (acc_wwe || acc_bwe);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = acc_err ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wwe_q   <= 1'b0;
      bwe_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wwe_q   <= wwe_d;
      bwe_q   <= bwe_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk     (clock),
    .rst     (reset),
    .we      (mem_we),
    .lane_en (mem_lanes),
    .idx     (acc_addr[2 +: IDX_W]),
    .wdata   (mem_wdata),
    .rdata   (mem_rdata)
  );

endmodule
